// File: rtl/pc_seq_if.sv
// pc_seq_if: flow-control bundle between the control path and pc_sequencer.
//   master : drives run control (start/stall/halt) and decoded flow strobes
//            (br_en/br_abs/br_target/br_off/call/ret); observes status.
//   slave  : the sequencer; drives pc, running, done, sp, err_ovf, err_unf,
//            cycles.
interface pc_seq_if #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 6,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) ();
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic             start;
    logic             stall;
    logic             halt;
    logic             br_en;
    logic             br_abs;
    logic [PC_W-1:0]  br_target;
    logic [OFF_W-1:0] br_off;
    logic             call;
    logic             ret;

    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [SP_W-1:0]  sp;
    logic             err_ovf;
    logic             err_unf;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, stall, halt, br_en, br_abs, br_target, br_off, call, ret,
        input  pc, running, done, sp, err_ovf, err_unf, cycles
    );

    modport slave (
        input  start, stall, halt, br_en, br_abs, br_target, br_off, call, ret,
        output pc, running, done, sp, err_ovf, err_unf, cycles
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program sequencer for the 9-bit CPU family.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_seq_if slave port
//           inputs  start, stall, halt, br_en, br_abs, br_target, br_off,
//                   call, ret
//           outputs pc (fetch address), running (RUN), done (HALT),
//                   sp (stack occupancy), err_ovf/err_unf (sticky stack
//                   errors), cycles (saturating RUN-cycle counter)
// Three-state run controller IDLE/RUN/HALT with a hardware return stack.
// Every output comes straight from a flop; strobes act at the next edge.
module pc_sequencer #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 6,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_seq_if.slave      bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]  SP_EMPTY = {SP_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [PC_W-1:0]  stack_q [0:STACK_DEPTH-1];
    logic [PC_W-1:0]  stack_d [0:STACK_DEPTH-1];

    logic [PC_W-1:0]  pc_inc_s;
    logic [PC_W-1:0]  off_ext_s;
    logic [SP_W-1:0]  sp_m1_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] push_idx_s;

    // Address arithmetic helpers; all pc sums wrap modulo 2**PC_W by width.
    always_comb begin
        pc_inc_s   = pc_q + PC_W'(1);
        off_ext_s  = {{(PC_W-OFF_W){bus.br_off[OFF_W-1]}}, bus.br_off};
        sp_m1_s    = sp_q - SP_W'(1);
        // Index slices are only used when sp is in range for that access.
        top_idx_s  = sp_m1_s[IDX_W-1:0];
        push_idx_s = sp_q[IDX_W-1:0];
    end

    // Next-state logic: run control plus prioritised pc selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        cycles_d  = cycles_q;
        stack_d   = stack_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    // A (re)start clears the whole run context.
                    state_d   = ST_RUN;
                    pc_d      = START_PC;
                    sp_d      = SP_EMPTY;
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                    cycles_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (cycles_q != CNT_MAX) begin
                    cycles_d = cycles_q + CNT_W'(1);
                end else begin
                    cycles_d = cycles_q;
                end

                // Priority chain: halt > stall > ret > call > branch > increment.
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.ret) begin
                    if (sp_q == SP_EMPTY) begin
                        err_unf_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        pc_d = stack_q[top_idx_s];
                        sp_d = sp_m1_s;
                    end
                end else if (bus.call) begin
                    if (sp_q == SP_FULL) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        stack_d[push_idx_s] = pc_inc_s;
                        pc_d = bus.br_target;
                        sp_d = sp_q + SP_W'(1);
                    end
                end else if (bus.br_en) begin
                    if (bus.br_abs) begin
                        pc_d = bus.br_target;
                    end else begin
                        pc_d = pc_q + off_ext_s;
                    end
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_HALT);
    end

    // Control and status flops, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            sp_q      <= SP_EMPTY;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            cycles_q  <= {CNT_W{1'b0}};
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            cycles_q  <= cycles_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Return-address storage; contents are meaningless while sp is zero,
    // so the array carries no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.pc      = pc_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.sp      = sp_q;
    assign bus.err_ovf = err_ovf_q;
    assign bus.err_unf = err_unf_q;
    assign bus.cycles  = cycles_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized bench for pc_sequencer, checked
// against a queue-based behavioural model of the sequencing rules.
module tb_pc_sequencer;
    localparam int PC_W = 10, OFF_W = 6, DEPTH = 4, START = 0, CNT_W = 16;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    pc_seq_if #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pc_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH),
        .START_ADDR(START), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_pc, m_cyc;
    bit m_run, m_done, m_ovf, m_unf;
    int m_stack[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = START; m_cyc = 0; m_run = 0; m_done = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endtask

    task automatic model_stop();
        m_run = 0; m_done = 1;
    endtask

    task automatic model_step();
        int so;
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (bus.start) begin
                m_pc = START; m_cyc = 0; m_ovf = 0; m_unf = 0;
                m_stack.delete(); m_run = 1; m_done = 0;
            end
        end else begin
            if (m_cyc < CNT_MAX) m_cyc = m_cyc + 1;
            if (bus.halt) model_stop();
            else if (bus.stall) begin end
            else if (bus.ret) begin
                if (m_stack.size() == 0) begin m_unf = 1; model_stop(); end
                else m_pc = m_stack.pop_back();
            end else if (bus.call) begin
                if (m_stack.size() == DEPTH) begin m_ovf = 1; model_stop(); end
                else begin
                    m_stack.push_back((m_pc + 1) % PC_MOD);
                    m_pc = int'(bus.br_target);
                end
            end else if (bus.br_en) begin
                if (bus.br_abs) m_pc = int'(bus.br_target);
                else begin
                    so = int'(bus.br_off);
                    if (so >= (1 << (OFF_W - 1))) so = so - (1 << OFF_W);
                    m_pc = (m_pc + so + PC_MOD) % PC_MOD;
                end
            end else m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},      32'(bus.pc),      32'(m_pc));
        chk({tag, ".running"}, 32'(bus.running), 32'(m_run));
        chk({tag, ".done"},    32'(bus.done),    32'(m_done));
        chk({tag, ".sp"},      32'(bus.sp),      32'(m_stack.size()));
        chk({tag, ".err_ovf"}, 32'(bus.err_ovf), 32'(m_ovf));
        chk({tag, ".err_unf"}, 32'(bus.err_unf), 32'(m_unf));
        chk({tag, ".cycles"},  32'(bus.cycles),  32'(m_cyc));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk_all(tag);
    endtask

    task automatic clear_in();
        bus.start = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0;
        bus.br_en = 1'b0; bus.br_abs = 1'b0; bus.br_target = '0;
        bus.br_off = '0; bus.call = 1'b0; bus.ret = 1'b0;
    endtask

    initial begin
        int exp_ret [4] = '{41, 31, 21, 11};
        int tgts [4]    = '{20, 30, 40, 50};

        // Reset and start
        rst_n = 1'b0; clear_in(); model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;
        cycle("idle"); chk("idle_pc", 32'(bus.pc), 32'd0);
        bus.start = 1'b1; cycle("start"); bus.start = 1'b0;
        chk("first_pc", 32'(bus.pc), 32'd0);
        repeat (5) cycle("run5");
        chk("pc5", 32'(bus.pc), 32'd5);
        chk("cyc5", 32'(bus.cycles), 32'd5);
        chk("run5_running", 32'(bus.running), 32'd1);

        // Relative branch with wrap
        bus.br_en = 1'b1; bus.br_abs = 1'b1; bus.br_target = 10'd3; cycle("abs3");
        bus.br_abs = 1'b0; bus.br_off = 6'b111011; cycle("rel_m5");
        chk("wrap_down", 32'(bus.pc), 32'd1022);
        bus.br_en = 1'b0; cycle("inc1023");
        bus.br_en = 1'b1; bus.br_off = 6'd2; cycle("rel_p2");
        chk("wrap_up", 32'(bus.pc), 32'd1);

        // Nested calls and returns
        bus.br_abs = 1'b1; bus.br_target = 10'd10; cycle("to10"); bus.br_en = 1'b0;
        bus.call = 1'b1;
        for (int i = 0; i < 4; i++) begin bus.br_target = 10'(tgts[i]); cycle("call"); end
        bus.call = 1'b0;
        chk("sp_full", 32'(bus.sp), 32'd4);
        chk("pc50", 32'(bus.pc), 32'd50);
        bus.ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("ret");
            chk("ret_pc", 32'(bus.pc), 32'(exp_ret[i]));
        end
        bus.ret = 1'b0;
        chk("sp_empty", 32'(bus.sp), 32'd0);
        bus.call = 1'b1;
        for (int i = 0; i < 4; i++) begin bus.br_target = 10'(60 + i); cycle("call2"); end
        bus.br_target = 10'd99; cycle("call_ovf"); bus.call = 1'b0;
        chk("ovf", 32'(bus.err_ovf), 32'd1);
        chk("ovf_done", 32'(bus.done), 32'd1);
        chk("ovf_pc", 32'(bus.pc), 32'd63);

        // Underflow and restart
        bus.start = 1'b1; cycle("restart1"); bus.start = 1'b0;
        chk("ovf_clr", 32'(bus.err_ovf), 32'd0);
        bus.ret = 1'b1; cycle("unf"); bus.ret = 1'b0;
        chk("unf", 32'(bus.err_unf), 32'd1);
        cycle("halt_hold");
        bus.start = 1'b1; cycle("restart2"); bus.start = 1'b0;
        chk("unf_clr", 32'(bus.err_unf), 32'd0);
        chk("restart_cyc", 32'(bus.cycles), 32'd0);

        // Priority
        bus.stall = 1'b1; bus.br_en = 1'b1; bus.br_abs = 1'b1; bus.br_target = 10'd200;
        cycle("stall_br"); bus.stall = 1'b0;
        chk("stall_hold", 32'(bus.pc), 32'd0);
        bus.br_target = 10'd7; cycle("to7");
        bus.call = 1'b1; bus.br_target = 10'd100; cycle("call_br");
        bus.call = 1'b0; bus.br_en = 1'b0;
        chk("call_wins", 32'(bus.pc), 32'd100);
        bus.ret = 1'b1; cycle("ret8"); bus.ret = 1'b0;
        chk("stack_top8", 32'(bus.pc), 32'd8);
        bus.halt = 1'b1; bus.stall = 1'b1; cycle("halt_stall");
        bus.halt = 1'b0; bus.stall = 1'b0;
        chk("halt_wins", 32'(bus.done), 32'd1);

        // Async reset mid-RUN
        bus.start = 1'b1; cycle("restart3"); bus.start = 1'b0;
        bus.call = 1'b1; bus.br_target = 10'd30; cycle("c30");
        bus.br_target = 10'd57; cycle("c57"); bus.call = 1'b0;
        chk("pre_rst_pc", 32'(bus.pc), 32'd57);
        chk("pre_rst_sp", 32'(bus.sp), 32'd2);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk_all("async_rst");
        chk("async_pc", 32'(bus.pc), 32'd0);
        bus.start = 1'b1; cycle("start_in_rst");
        chk("start_ignored", 32'(bus.running), 32'd0);
        bus.start = 1'b0; rst_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bus.start     = ($urandom % 4) == 0;
            bus.stall     = ($urandom % 5) == 0;
            bus.halt      = ($urandom % 20) == 0;
            bus.ret       = ($urandom % 6) == 0;
            bus.call      = ($urandom % 6) == 0;
            bus.br_en     = ($urandom % 3) == 0;
            bus.br_abs    = 1'($urandom);
            bus.br_target = 10'($urandom);
            bus.br_off    = 6'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-sequencing unit for the 9-bit CPU family. It replaces the bare program counter with a start/done run controller, stall support, relative and absolute branches, and a hardware call/return stack of configurable depth. It sits between control_logic, which supplies the decoded flow-control strobes, and instr_memory, which it addresses via pc.

Parameters:
PC_W, 10, program counter width; instruction memory depth is 2**PC_W.
OFF_W, 6, width of the signed relative-branch offset.
STACK_DEPTH, 4, number of return-address entries (>=1).
START_ADDR, 0, pc value on reset and on every (re)start.
CNT_W, 16, width of the run-cycle counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin execution; sampled in IDLE and HALT only.
stall  in  1  freeze pc this cycle.
halt  in  1  executing instruction is a halt.
br_en  in  1  branch taken.
br_abs  in  1  1: absolute target; 0: relative offset.
br_target  in  PC_W  absolute branch/call target.
br_off  in  OFF_W  signed relative offset, two's complement.
call  in  1  push return address, jump to br_target.
ret  in  1  pop return address into pc.
pc  out  PC_W  current instruction address.
running  out  1  high in RUN.
done  out  1  high in HALT.
sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
err_ovf  out  1  sticky: call with full stack.
err_unf  out  1  sticky: ret with empty stack.
cycles  out  CNT_W  RUN cycles since last start, saturating.

Behaviour:
- Reset, asynchronous: state=IDLE, pc=START_ADDR, sp=0, err_*=0, cycles=0, running=0, done=0. Stack contents don't-care.
- States IDLE, RUN, HALT. All outputs are registered.
- IDLE: start=1 -> RUN at next edge. pc stays START_ADDR, so the first fetch is at START_ADDR.
- RUN: cycles increments each RUN cycle, saturating at 2**CNT_W-1. Next pc is chosen by priority, highest first:
  1. halt: state->HALT, pc holds. Honoured even with stall=1.
  2. stall: pc holds. br_en/call/ret are ignored.
  3. ret: sp==0 -> err_unf=1, state->HALT, pc holds. Otherwise pc=top of stack, sp-1.
  4. call: sp==STACK_DEPTH -> err_ovf=1, state->HALT, pc holds. Otherwise push pc+1, pc=br_target, sp+1.
  5. br_en: br_abs=1 -> pc=br_target. Otherwise pc = pc + sign_extend(br_off).
  6. default: pc=pc+1.
- All pc arithmetic is modulo 2**PC_W. Increment and relative branches wrap silently. A pushed return address wraps the same way.
- Multiple strobes in one cycle resolve by the priority above. The lower ones have no effect, including no stack side effects.
- HALT: done=1, and pc, sp, errors and cycles hold. start=1 -> RUN next edge with pc=START_ADDR, sp=0, err_*=0, cycles=0.
- start is ignored in RUN.
- rst_n asserted mid-operation returns everything to reset values immediately, regardless of state.
- Latency: every strobe affects pc at the next rising edge. Zero-cycle combinational paths from inputs to outputs are not allowed.

Test Plan:
- Reset, then start: pc=0 in IDLE; pulse start; pc stays 0 one cycle; after 5 RUN cycles pc=5, running=1, cycles=5.
- Relative branch with wrap: pc=3, br_en=1, br_abs=0, br_off=-5 (6'b111011) -> pc=1022. Then pc=1023, br_off=+2 -> pc=1.
- Nested calls: 4 calls from pc=10,20,30,40 to targets 20,30,40,50 -> sp=4. 4 rets -> pc 41,31,21,11, sp=0. A 5th call at sp=4 -> err_ovf=1, done=1, pc holds.
- Underflow and restart: ret at sp=0 -> err_unf=1, HALT. Pulse start -> err_unf=0, pc=0, cycles=0, running=1.
- Priority: stall+br_en -> pc holds. halt+stall -> HALT. call+br_en (target 100, pc=7) -> pc=100, stack top 8.
- Async reset mid-RUN (pc=57, sp=2), asserted between edges: all outputs reset before the next clock edge. start ignored while rst_n=0.
